// File: rtl/multdiv_result.sv
// Result-side stage of the multiply/divide path: tracks the in-flight op, stalls upstream,
// and turns the multdiv result into one held writeback request. Optional: MULTDIV_TIMEOUT_EN.
module multdiv_result #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] inIR,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  input  logic        wb_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  state_dbg
);

  // Handshake: wb_valid stays high with wb_rd/wb_data frozen until the cycle wb_ack is
  // sampled high; that edge retires the request.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t      state, state_n;
  logic [4:0]  rd_q, rd_n;
  logic        op_div, op_div_n;
  logic        wb_valid_n;
  logic [4:0]  wb_rd_n;
  logic [31:0] wb_data_n;
  logic        start;
  logic        timeout;
  logic [31:0] rstatus;
  logic        unused_ok;

  assign start   = ctrl_MULT | ctrl_DIV;
  assign rstatus = op_div ? 32'd5 : 32'd4;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt, cnt_n;
  assign timeout   = (cnt == CNT_LAST);
  assign unused_ok = ^{inIR[31:27], inIR[21:0]};
`else
  assign timeout   = 1'b0;
  assign unused_ok = ^{inIR[31:27], inIR[21:0], 8'(TIMEOUT_CYCLES)};
`endif

  assign stall = (state != IDLE) |
                 (((state == IDLE) | ((state == HOLD) & wb_ack)) & start);
  assign state_dbg = state;

  always_comb begin
    state_n    = state;
    rd_n       = rd_q;
    op_div_n   = op_div;
    wb_valid_n = wb_valid;
    wb_rd_n    = wb_rd;
    wb_data_n  = wb_data;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_n      = cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = BUSY;
          rd_n     = inIR[26:22];
          op_div_n = ctrl_DIV;
`ifdef MULTDIV_TIMEOUT_EN
          cnt_n    = 8'd0;
`endif
        end
      end
      BUSY: begin
`ifdef MULTDIV_TIMEOUT_EN
        cnt_n = cnt + 8'd1;
`endif
        if (data_resultRDY && !data_exception) begin
          if (rd_q == 5'd0) begin
            state_n = IDLE;
          end else begin
            state_n    = HOLD;
            wb_valid_n = 1'b1;
            wb_rd_n    = rd_q;
            wb_data_n  = data_result;
          end
        end else if (data_resultRDY || timeout) begin
          // Faults and timeouts report through rstatus (r30)
          state_n    = HOLD;
          wb_valid_n = 1'b1;
          wb_rd_n    = 5'd30;
          wb_data_n  = rstatus;
        end
      end
      HOLD: begin
        if (wb_ack) begin
          wb_valid_n = 1'b0;
          if (start) begin
            state_n  = BUSY;
            rd_n     = inIR[26:22];
            op_div_n = ctrl_DIV;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_n    = 8'd0;
`endif
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_q     <= 5'd0;
      op_div   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      state    <= state_n;
      rd_q     <= rd_n;
      op_div   <= op_div_n;
      wb_valid <= wb_valid_n;
      wb_rd    <= wb_rd_n;
      wb_data  <= wb_data_n;
    end
  end

`ifdef MULTDIV_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= 8'd0;
    else       cnt <= cnt_n;
  end
`endif

endmodule

// File: tb/tb_multdiv_result.sv
// Directed bench for multdiv_result: reset, normal ops, exceptions, rd=0, back-to-back,
// and the timeout / no-timeout behaviour of BUSY.
module tb_multdiv_result;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] inIR = 32'd0;
  logic [31:0] data_result = 32'd0;
  logic        data_exception = 1'b0;
  logic        data_resultRDY = 1'b0;
  logic        wb_ack = 1'b0;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  multdiv_result #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .inIR(inIR), .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .wb_ack(wb_ack), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later still.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input bit div, input logic [4:0] rd);
    tick();
    ctrl_MULT = !div;
    ctrl_DIV  = div;
    inIR      = {5'd0, rd, 22'($urandom)};
    #1 chk("start_stall", stall, 1);
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    inIR      = $urandom;
    #1 chk("busy_state", state_dbg, S_BUSY);
    chk("busy_stall", stall, 1);
  endtask

  task automatic wait_busy(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      #1 chk("wait_stall", stall, 1);
    end
  endtask

  // Pulses RDY for one cycle; returns in the following cycle (HOLD or IDLE)
  task automatic give_rdy(input logic [31:0] res, input bit exc);
    tick();
    data_resultRDY = 1'b1;
    data_result    = res;
    data_exception = exc;
    tick();
    data_resultRDY = 1'b0;
    data_result    = $urandom;
    data_exception = 1'b0;
    #1;
  endtask

  // Scoreboard: compare the held request against the queue head, ack it, confirm release
  task automatic ack_wb(input string tag);
    logic [36:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h1f_ffff_ffff;
    chk({tag, "_valid"}, wb_valid, 1);
    chk({tag, "_rd_data"}, {wb_rd, wb_data}, e);
    wb_ack = 1'b1;
    #1 chk({tag, "_ack_stall"}, stall, 1);
    tick();
    wb_ack = 1'b0;
    #1 chk({tag, "_idle_state"}, state_dbg, S_IDLE);
    chk({tag, "_idle_stall"}, stall, 0);
    chk({tag, "_idle_valid"}, wb_valid, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_state", state_dbg, S_IDLE);
    reset = 1'b0;

    // Normal MULT: rd=5, RDY four cycles after start, immediate ack
    start_op(0, 5'd5);
    wait_busy(2);
    give_rdy(32'd42, 0);
    chk("mult_state", state_dbg, S_HOLD);
    exp_q.push_back({5'd5, 32'd42});
    ack_wb("mult");

    // DIV by zero -> rstatus 5
    start_op(1, 5'd7);
    give_rdy(32'd123, 1);
    exp_q.push_back({5'd30, 32'd5});
    ack_wb("div0");

    // MULT overflow -> rstatus 4
    start_op(0, 5'd9);
    wait_busy(1);
    give_rdy(32'h8000_0000, 1);
    exp_q.push_back({5'd30, 32'd4});
    ack_wb("movf");

    // rd=0 without exception: no writeback, IDLE right after RDY
    start_op(0, 5'd0);
    give_rdy(32'd55, 0);
    chk("rd0_valid", wb_valid, 0);
    chk("rd0_state", state_dbg, S_IDLE);
    chk("rd0_stall", stall, 0);

    // RDY while IDLE is ignored
    tick();
    data_resultRDY = 1'b1;
    data_result    = 32'd99;
    tick();
    data_resultRDY = 1'b0;
    #1 chk("idle_rdy_valid", wb_valid, 0);
    chk("idle_rdy_state", state_dbg, S_IDLE);

    // Back-to-back: ack delayed 3 cycles, new DIV in the ack cycle
    start_op(0, 5'd12);
    give_rdy(32'hdead_beef, 0);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_hold_valid", wb_valid, 1);
      chk("b2b_hold_out", {wb_rd, wb_data}, {5'd12, 32'hdead_beef});
      chk("b2b_hold_stall", stall, 1);
      tick();
      #1;
    end
    wb_ack   = 1'b1;
    ctrl_DIV = 1'b1;
    inIR     = {5'd0, 5'd3, 22'h155};
    #1 chk("b2b_ack_stall", stall, 1);
    chk("b2b_ack_out", {wb_rd, wb_data}, {5'd12, 32'hdead_beef});
    tick();
    wb_ack   = 1'b0;
    ctrl_DIV = 1'b0;
    inIR     = $urandom;
    #1 chk("b2b_busy_state", state_dbg, S_BUSY);
    chk("b2b_busy_stall", stall, 1);
    chk("b2b_busy_valid", wb_valid, 0);
    give_rdy(32'd77, 0);
    exp_q.push_back({5'd3, 32'd77});
    ack_wb("b2b2");

    // DIV after a MULT: op-type must follow the new op (rstatus 5)
    start_op(1, 5'd4);
    give_rdy(32'd0, 1);
    exp_q.push_back({5'd30, 32'd5});
    ack_wb("div2");

    // Asynchronous reset mid-BUSY (wb_rd/wb_data still hold the last writeback)
    start_op(0, 5'd8);
    wait_busy(1);
    #3 reset = 1'b1;
    #1 chk("arst_stall", stall, 0);
    chk("arst_valid", wb_valid, 0);
    chk("arst_rd", wb_rd, 0);
    chk("arst_data", wb_data, 0);
    chk("arst_state", state_dbg, S_IDLE);
    #1 reset = 1'b0;
    tick();
    data_resultRDY = 1'b1;
    data_result    = 32'd11;
    tick();
    data_resultRDY = 1'b0;
    #1 chk("arst_late_valid", wb_valid, 0);
    chk("arst_late_state", state_dbg, S_IDLE);
    chk("arst_late_stall", stall, 0);

`ifdef MULTDIV_TIMEOUT_EN
    // Timeout with TIMEOUT_CYCLES=8: eight BUSY cycles, then HOLD with rstatus
    start_op(0, 5'd6);
    for (int i = 0; i < 7; i++) begin
      tick();
      #1 chk("to_busy", state_dbg, S_BUSY);
    end
    tick();
    #1 chk("to_hold", state_dbg, S_HOLD);
    exp_q.push_back({5'd30, 32'd4});
    ack_wb("to");
`else
    // No timeout: BUSY holds for 100 cycles
    start_op(0, 5'd6);
    for (int i = 0; i < 100; i++) begin
      tick();
      #1 chk("nto_busy", state_dbg, S_BUSY);
    end
    give_rdy(32'd600, 0);
    exp_q.push_back({5'd6, 32'd600});
    ack_wb("nto");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multdiv_result.md
# multdiv_result

Result-side stage of the multiply/divide path. It is the counterpart of the operand latch that captures A/B/IR and pulses `ctrl_MULT`/`ctrl_DIV`. The block tracks the outstanding multdiv operation and stalls the pipeline while it is in flight. It captures `data_result`/`data_exception` when `data_resultRDY` fires, then presents one register-file writeback request, held until acknowledged. It sits between the multdiv unit output and the writeback mux.

## Interface
- `TIMEOUT_CYCLES`, 64: max BUSY cycles before forced abort; range 2..255; used only with `MULTDIV_TIMEOUT_EN`.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ctrl_MULT`  in  1  one-cycle start pulse for a multiply.
- `ctrl_DIV`  in  1  one-cycle start pulse for a divide.
- `inIR`  in  32  latched instruction; `inIR[26:22]` is the destination register rd.
- `data_result`  in  32  multdiv product/quotient.
- `data_exception`  in  1  overflow or divide-by-zero; valid with `data_resultRDY`.
- `data_resultRDY`  in  1  one-cycle result-valid pulse from multdiv.
- `wb_ack`  in  1  writeback slot granted this cycle.
- `stall`  out  1  freeze upstream stages.
- `wb_valid`  out  1  writeback request pending.
- `wb_rd`  out  5  writeback destination.
- `wb_data`  out  32  writeback value.

## Operation
- States: IDLE, BUSY, HOLD. Reset: state IDLE; `wb_valid`=0, `wb_rd`=0, `wb_data`=0, op-type=0, timeout counter=0; `stall`=0.
- **IDLE:** `ctrl_MULT|ctrl_DIV` is a start.
  - On start: capture rd = `inIR[26:22]`, op-type (DIV if `ctrl_DIV`; DIV wins if both are high), clear counter, go to BUSY.
- **BUSY:** on `data_resultRDY`:
  - No exception: `wb_data`=`data_result`, `wb_rd`=captured rd.
  - Exception: `wb_rd`=30, `wb_data`=4 for MULT or 5 for DIV (rstatus).
  - Then go to HOLD. Exception: if there is no exception and rd==0, return directly to IDLE with no writeback.
- **HOLD:** `wb_valid`=1. Outputs are held stable until `wb_ack`, then go to IDLE.
  - If a start arrives in the same cycle as `wb_ack`, accept it and go to BUSY.
- `stall` is combinational: `stall = (state!=IDLE) | ((state==IDLE|(state==HOLD&wb_ack)) & start)`. It is therefore high in the start cycle itself.
- Ignored inputs:
  - Start in BUSY, or in HOLD without `wb_ack`: ignored (upstream is stalled; this must not occur).
  - `data_resultRDY` in IDLE or HOLD: ignored.
- Reset mid-operation: returns to IDLE at once. Any pending writeback is dropped; the in-flight multdiv result is later ignored.

## Timing
- Cycle 0: start pulse sampled, `stall`=1.
- Cycle 1: BUSY.
- Cycle k: `data_resultRDY` sampled.
- Cycle k+1: HOLD, `wb_valid`=1 with data.
- With `wb_ack` in k+1: IDLE in k+2, `stall`=0 in k+2.
- Minimum start-to-free is 3 cycles.
- `wb_rd`/`wb_data`/`wb_valid` are registered. `stall` is combinational.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - An 8-bit counter increments each BUSY cycle.
  - If it reaches `TIMEOUT_CYCLES`-1 without `data_resultRDY`, the block takes the exception path (rd=30, value 4/5) and goes to HOLD.
  - A `data_resultRDY` in the same cycle as the timeout wins over the timeout.
- Not defined: no counter; BUSY waits indefinitely for `data_resultRDY`.

## Test plan
- **Reset:** assert `reset` mid-BUSY, asynchronously between edges -> `stall`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0 immediately. A later `data_resultRDY` produces no writeback.
- **Normal MULT:**
  - Stimulus: `ctrl_MULT` with rd=5, `data_resultRDY` with `data_result`=42 four cycles later, `wb_ack` immediate.
  - Required: `wb_valid` one cycle after RDY with rd=5, data=42. `stall` high from the start cycle through the ack cycle.
- **DIV by zero:** `ctrl_DIV` with rd=7, RDY with `data_exception`=1 -> `wb_rd`=30, `wb_data`=5. MULT overflow -> `wb_data`=4.
- **rd=0:** MULT to rd=0 with no exception -> `wb_valid` never asserts; IDLE the cycle after RDY.
- **Back-to-back:**
  - Stimulus: HOLD with `wb_ack` delayed 3 cycles, then a new `ctrl_DIV` in the ack cycle.
  - Required: outputs stable during the wait; the new op is captured; `stall` stays high continuously.
- **Timeout (`MULTDIV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** MULT with no RDY -> HOLD after 8 BUSY cycles with `wb_rd`=30, `wb_data`=4. Without the macro -> remains BUSY for 100 cycles.
